// File: rtl/seven_segment_decoder.sv
// Registered nibble-to-7-segment decoder with lamp test, blanking and hold.
// Segment order {g,f,e,d,c,b,a}; ACTIVE_LOW inverts the whole pattern.
module seven_segment_decoder #(
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit HEX_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] bin,
    input  logic       lamp_test,
    input  logic       blank,
    output logic [6:0] seg
);

    localparam logic [6:0] ALL_ON  = 7'h7f;
    localparam logic [6:0] ALL_OFF = 7'h00;
    localparam logic [6:0] POL     = {7{ACTIVE_LOW}};

    logic [6:0] dec;
    logic [6:0] pat;

    always_comb begin
        dec = ALL_OFF;
        case (bin)
            4'h0:    dec = 7'h3f;
            4'h1:    dec = 7'h06;
            4'h2:    dec = 7'h5b;
            4'h3:    dec = 7'h4f;
            4'h4:    dec = 7'h66;
            4'h5:    dec = 7'h6d;
            4'h6:    dec = 7'h7d;
            4'h7:    dec = 7'h07;
            4'h8:    dec = 7'h7f;
            4'h9:    dec = 7'h6f;
            4'ha:    dec = HEX_EN ? 7'h77 : ALL_OFF;
            4'hb:    dec = HEX_EN ? 7'h7c : ALL_OFF;
            4'hc:    dec = HEX_EN ? 7'h39 : ALL_OFF;
            4'hd:    dec = HEX_EN ? 7'h5e : ALL_OFF;
            4'he:    dec = HEX_EN ? 7'h79 : ALL_OFF;
            4'hf:    dec = HEX_EN ? 7'h71 : ALL_OFF;
            default: dec = ALL_OFF;
        endcase
    end

    // Lamp test wins over blank so a stuck blank line cannot hide a lamp check.
    always_comb begin
        pat = dec;
        if (lamp_test) begin
            pat = ALL_ON;
        end else if (blank) begin
            pat = ALL_OFF;
        end
    end

    // Polarity applied last so every control keeps its logical meaning.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= ALL_OFF ^ POL;
        end else if (en) begin
            seg <= pat ^ POL;
        end
    end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Scoreboard bench: three decoder builds share stimulus.
// Expected patterns are queued at drive time and checked by a monitor.
module tb_seven_segment_decoder;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] bin;
    logic       lamp_test;
    logic       blank;
    logic [6:0] seg_hex;
    logic [6:0] seg_dec;
    logic [6:0] seg_low;

    int checks;
    int passed;

    typedef struct {
        logic [6:0] hex;
        logic [6:0] dec;
        string      tag;
    } exp_t;

    exp_t q[$];

    seven_segment_decoder #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) u_hex (
        .clk(clk), .rst(rst), .en(en), .bin(bin),
        .lamp_test(lamp_test), .blank(blank), .seg(seg_hex)
    );

    seven_segment_decoder #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b0)) u_dec (
        .clk(clk), .rst(rst), .en(en), .bin(bin),
        .lamp_test(lamp_test), .blank(blank), .seg(seg_dec)
    );

    seven_segment_decoder #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) u_low (
        .clk(clk), .rst(rst), .en(en), .bin(bin),
        .lamp_test(lamp_test), .blank(blank), .seg(seg_low)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [6:0] act,
                         input logic [6:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: seg=%h expected=%h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; the next rising edge captures them.
    task automatic step(input logic r, input logic e, input logic [3:0] b,
                        input logic lt, input logic bl,
                        input logic [6:0] xh, input logic [6:0] xd,
                        input string tag);
        exp_t x;
        @(negedge clk);
        rst       = r;
        en        = e;
        bin       = b;
        lamp_test = lt;
        blank     = bl;
        x.hex = xh;
        x.dec = xd;
        x.tag = tag;
        q.push_back(x);
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check({x.tag, "/hex"}, seg_hex, x.hex);
                check({x.tag, "/dec"}, seg_dec, x.dec);
                check({x.tag, "/low"}, seg_low, ~x.hex);
            end
        end
    end

    logic [6:0] digits [10] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66,
                                7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};
    logic [6:0] letters [6] = '{7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};

    initial begin
        int guard;
        rst       = 1'b1;
        en        = 1'b1;
        bin       = 4'h8;
        lamp_test = 1'b1;
        blank     = 1'b0;
        checks    = 0;
        passed    = 0;

        step(1, 1, 4'h8, 1, 0, 7'h00, 7'h00, "reset0");
        step(1, 1, 4'h8, 1, 0, 7'h00, 7'h00, "reset1");

        for (int i = 0; i < 10; i++) begin
            step(0, 1, 4'(i), 0, 0, digits[i], digits[i],
                 $sformatf("digit%0d", i));
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 4'(10 + i), 0, 0, letters[i], 7'h00,
                 $sformatf("hex%0d", 10 + i));
        end

        step(0, 1, 4'h3, 0, 0, 7'h4f, 7'h4f, "load3");
        step(0, 0, 4'h8, 0, 0, 7'h4f, 7'h4f, "hold0");
        step(0, 0, 4'h8, 1, 0, 7'h4f, 7'h4f, "hold_lt");
        step(0, 0, 4'h1, 0, 1, 7'h4f, 7'h4f, "hold_bl");
        step(0, 1, 4'h8, 0, 0, 7'h7f, 7'h7f, "reload8");

        step(0, 1, 4'h2, 1, 0, 7'h7f, 7'h7f, "lamp");
        step(0, 1, 4'h2, 0, 1, 7'h00, 7'h00, "blank");
        step(0, 1, 4'h2, 1, 1, 7'h7f, 7'h7f, "lamp_blank");
        step(0, 1, 4'ha, 1, 0, 7'h7f, 7'h7f, "lamp_hexA");
        step(0, 1, 4'hc, 0, 1, 7'h00, 7'h00, "blank_hexC");

        step(0, 1, 4'h8, 0, 0, 7'h7f, 7'h7f, "pre_rst");
        step(1, 0, 4'h8, 1, 0, 7'h00, 7'h00, "mid_rst");
        step(0, 0, 4'h5, 0, 0, 7'h00, 7'h00, "hold_rst");
        step(0, 1, 4'h0, 0, 0, 7'h3f, 7'h3f, "zero");
        step(0, 1, 4'h1, 0, 0, 7'h06, 7'h06, "one");

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: pending=%0d expected=0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
